// File: rtl/te_frame_scheduler.sv
// Round-robin front end for turbo_encoder (serial mode); one frame in flight, first out_valid OUT_DELAY+1 cycles after te_ack.
// No backpressure on the output; requesters simply wait while busy. Optional TE_SCHED_STATS_EN adds stat_frames/stat_stall.
module te_frame_scheduler #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 1148,
    parameter int OUT_DELAY = 3452,
    parameter int OUT_LEN   = 3456
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] src_bit,
    output logic [N_REQ-1:0] grant,
    output logic [10:0]      bit_idx,
    output logic             te_mode,
    output logic             te_ack,
    output logic             te_in,
    input  logic             te_out,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic [2:0]       out_src,
    output logic             busy
`ifdef TE_SCHED_STATS_EN
    ,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_stall
`endif
);

    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW = SW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    logic [SW-1:0]    r_rr_ptr;
    logic [SW-1:0]    r_sel;
    logic [N_REQ-1:0] r_grant;
    logic [10:0]      r_bit_idx;
    logic             r_ack;
    logic [12:0]      r_dly;
    logic [12:0]      r_out_cnt;
    logic             r_out_vld;
    logic             r_out_bit;
    logic             r_out_last;
    logic [SW-1:0]    r_out_src;

    logic             w_any;
    logic             w_found;
    logic [SW-1:0]    w_sel;
    logic [SW-1:0]    w_nxt;
    logic [IW-1:0]    w_idx;

    // Rotating priority: scan from rr_ptr upward, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + IW'(i);
            if (w_idx >= IW'(N_REQ)) begin
                w_idx = w_idx - IW'(N_REQ);
            end
            if (!w_found && req[w_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[SW-1:0];
            end
        end
    end

    assign w_any = |req;
    assign w_nxt = (w_sel == SW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_grant    <= '0;
            r_bit_idx  <= '0;
            r_ack      <= 1'b0;
            r_dly      <= '0;
            r_out_cnt  <= '0;
            r_out_vld  <= 1'b0;
            r_out_bit  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_src  <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state   <= S_LOAD;
                        r_ack     <= 1'b1;
                        r_sel     <= w_sel;
                        r_grant   <= N_REQ'(1) << w_sel;
                        r_rr_ptr  <= w_nxt;
                        r_bit_idx <= '0;
                        r_dly     <= '0;
                    end
                end
                S_LOAD: begin
                    r_dly <= r_dly + 1'b1;
                    if (r_bit_idx == 11'(FRAME_LEN - 1)) begin
                        r_grant   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    // te_out holds encoded bit 0 in the cycle the delay count hits OUT_DELAY.
                    if (r_dly == 13'(OUT_DELAY)) begin
                        r_state    <= S_DRAIN;
                        r_dly      <= '0;
                        r_out_vld  <= 1'b1;
                        r_out_bit  <= te_out;
                        r_out_cnt  <= '0;
                        r_out_last <= (OUT_LEN == 1);
                        r_out_src  <= r_sel;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_out_cnt == 13'(OUT_LEN - 1)) begin
                        r_state    <= S_IDLE;
                        r_out_vld  <= 1'b0;
                        r_out_bit  <= 1'b0;
                        r_out_last <= 1'b0;
                        r_out_src  <= '0;
                        r_out_cnt  <= '0;
                    end else begin
                        r_out_bit  <= te_out;
                        r_out_cnt  <= r_out_cnt + 1'b1;
                        r_out_last <= (r_out_cnt == 13'(OUT_LEN - 2));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign bit_idx   = r_bit_idx;
    assign te_mode   = 1'b0;
    assign te_ack    = r_ack;
    assign te_in     = (r_state == S_LOAD) ? src_bit[r_sel] : 1'b0;
    assign out_valid = r_out_vld;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;
    assign out_src   = 3'(r_out_src);
    assign busy      = (r_state != S_IDLE);

`ifdef TE_SCHED_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_frames <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (r_out_vld && r_out_last && (r_stat_frames != 16'hFFFF)) begin
                r_stat_frames <= r_stat_frames + 1'b1;
            end
            if (w_any && (r_state != S_IDLE) && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 1'b1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_te_frame_scheduler.sv
// Scoreboard bench for te_frame_scheduler: stimulus queues expected acks/frames, monitors pop and compare.
module tb_te_frame_scheduler;

    localparam int NR  = 4;
    localparam int FL  = 1148;
    localparam int OD  = 3452;
    localparam int OL  = 3456;
    localparam int SPC = OD + OL + 2;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] src_bit;
    logic [NR-1:0] grant;
    logic [10:0]   bit_idx;
    logic          te_mode;
    logic          te_ack;
    logic          te_in;
    logic          te_out;
    logic          out_valid;
    logic          out_bit;
    logic          out_last;
    logic [2:0]    out_src;
    logic          busy;
`ifdef TE_SCHED_STATS_EN
    logic [15:0]   stat_frames;
    logic [15:0]   stat_stall;
`endif

    te_frame_scheduler #(
        .N_REQ(NR), .FRAME_LEN(FL), .OUT_DELAY(OD), .OUT_LEN(OL)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .src_bit(src_bit),
        .grant(grant), .bit_idx(bit_idx), .te_mode(te_mode),
        .te_ack(te_ack), .te_in(te_in), .te_out(te_out),
        .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
        .out_src(out_src), .busy(busy)
`ifdef TE_SCHED_STATS_EN
        , .stat_frames(stat_frames), .stat_stall(stat_stall)
`endif
    );

    typedef struct {
        int src;
        int ack_cyc;
    } exp_t;

    exp_t ack_q[$];
    exp_t out_q[$];
    int   cyc;
    int   checks;
    int   failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic f_enc(int c);
        logic [31:0] v;
        v = c * 32'h9E3779B1;
        return v[19] ^ v[7];
    endfunction

    function automatic logic f_src(int s, int k);
        logic [31:0] v;
        v = (k + s * 1013 + 7) * 32'h85EBCA6B;
        return v[21];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_grant"},     grant,     0);
        chk({tag, "_bit_idx"},   bit_idx,   0);
        chk({tag, "_te_ack"},    te_ack,    0);
        chk({tag, "_te_in"},     te_in,     0);
        chk({tag, "_te_mode"},   te_mode,   0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_bit"},   out_bit,   0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_out_src"},   out_src,   0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    task automatic push(int s, int a, bit completes);
        exp_t e;
        e.src     = s;
        e.ack_cyc = a;
        ack_q.push_back(e);
        if (completes) out_q.push_back(e);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Source and encoder stand-ins, updated just after each rising edge.
    initial begin
        cyc     = 0;
        te_out  = f_enc(0);
        src_bit = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            te_out = f_enc(cyc);
            for (int i = 0; i < NR; i++) src_bit[i] = f_src(i, int'(bit_idx));
        end
    end

    initial begin : mon_load
        exp_t e;
        int   k;
        int   s;
        bit   act;
        k = 0; s = 0; act = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
                continue;
            end
            if (te_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", te_ack, 0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_cyc", cyc, e.ack_cyc);
                    s = e.src; k = 0; act = 1'b1;
                end
            end
            if (act) begin
                if (k < FL) begin
                    chk("grant",   grant,   1 << s);
                    chk("bit_idx", bit_idx, k);
                    chk("te_in",   te_in,   f_src(s, k));
                    chk("busy",    busy,    1);
                    k++;
                end else begin
                    chk("grant_drop", grant, 0);
                    act = 1'b0;
                end
            end
        end
    end

    initial begin : mon_out
        exp_t e;
        int   k;
        bit   act;
        k = 0; act = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!act) begin
                    if (out_q.size() == 0) begin
                        chk("unexpected_out_valid", out_valid, 0);
                        continue;
                    end
                    e = out_q.pop_front();
                    k = 0; act = 1'b1;
                    chk("first_valid_cyc", cyc, e.ack_cyc + OD + 1);
                end
                chk("out_bit",  out_bit,  f_enc(e.ack_cyc + OD + k));
                chk("out_src",  out_src,  e.src);
                chk("out_last", out_last, (k == OL - 1));
                k++;
                if (k == OL) act = 1'b0;
            end else if (act) begin
                chk("valid_gap", out_valid, 1);
                act = 1'b0;
            end else begin
                chk("last_idle", out_last, 0);
            end
        end
    end

    initial begin : stim
        int a;
        rst = 1'b1;
        req = '0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("rst0");
        end
        rst = 1'b0;

        // Single frame from source 2.
        @(negedge clk);
        req = 4'b0100;
        a = cyc + 1;
        push(2, a, 1'b1);
        @(negedge clk);
        req = '0;
        wait_until(a + SPC - 1);

        // rr_ptr is 3: requests on 0 and 1 must wrap to 0 first.
        req = 4'b0011;
        a = cyc + 1;
        push(0, a, 1'b1);
        push(1, a + SPC, 1'b1);
        wait_until(a + SPC);
        req = '0;
        wait_until(a + 2 * SPC - 1);

        // Abort a frame mid-load; pointer must restart at 0.
        req = 4'b0001;
        a = cyc + 1;
        push(0, a, 1'b0);
        wait_until(a + 100);
        rst = 1'b1;
        req = '0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("rst_mid");
        end
        rst = 1'b0;

        // All sources held: 0,1,2,3,0 spaced by the full frame turnaround.
        req = 4'b1111;
        a = cyc + 1;
        for (int j = 0; j < 5; j++) push(j % NR, a + j * SPC, 1'b1);
        wait_until(a + 4 * SPC);
        req = '0;
        wait_until(a + 5 * SPC + 5);

        chk("ack_q_left", ack_q.size(), 0);
        chk("out_q_left", out_q.size(), 0);
        chk_idle("end");
`ifdef TE_SCHED_STATS_EN
        chk("stat_frames", stat_frames, 5);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
